// File: rtl/key_debouncer.sv
// key_debouncer
//   Multi-channel key debouncer with press/release edge pulses and
//   per-channel auto-repeat. Every channel runs identical logic; only its
//   repeat_mask_p bit differs.
//
// Parameters
//   width_p          number of independent key channels
//   active_low_p     1: raw 0 means pressed, 0: raw 1 means pressed
//   stable_cycles_p  consecutive agreeing synchronized samples to change state
//   repeat_delay_p   cycles from the press pulse to the first repeat pulse
//   repeat_period_p  cycles between subsequent repeat pulses
//   repeat_mask_p    bit i = 1 enables auto-repeat on channel i
//
// Ports
//   clk_i      clock, all state on the rising edge
//   reset_n_i  asynchronous active-low reset
//   keys_i     raw asynchronous key levels
//   level_o    debounced state, 1 = pressed
//   press_o    one-cycle pulse in the first cycle level_o is 1
//   release_o  one-cycle pulse in the first cycle level_o is 0 after a press
//   repeat_o   one-cycle auto-repeat pulse
//   trig_o     press_o | repeat_o
module key_debouncer #(
  parameter int                 width_p         = 5,
  parameter int                 active_low_p    = 1,
  parameter int                 stable_cycles_p = 4,
  parameter int                 repeat_delay_p  = 12,
  parameter int                 repeat_period_p = 3,
  parameter logic [width_p-1:0] repeat_mask_p   = '1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] keys_i,
  output logic [width_p-1:0] level_o,
  output logic [width_p-1:0] press_o,
  output logic [width_p-1:0] release_o,
  output logic [width_p-1:0] repeat_o,
  output logic [width_p-1:0] trig_o
);

  localparam int CNT_W    = $clog2(stable_cycles_p + 1);
  localparam int HOLD_MAX = (repeat_delay_p > repeat_period_p) ? repeat_delay_p
                                                               : repeat_period_p;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(stable_cycles_p - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT    = HOLD_W'(HOLD_MAX);
  localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(repeat_delay_p - 1);
  localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(repeat_period_p - 1);

  // Saturating increment keeps the hold counter from wrapping.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    return (v == HOLD_SAT) ? v : v + HOLD_W'(1);
  endfunction

  logic [width_p-1:0]             sync1_q, sync1_d;
  logic [width_p-1:0]             sync2_q, sync2_d;
  logic [width_p-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [width_p-1:0]             level_q, level_d;
  logic [width_p-1:0]             press_q, press_d;
  logic [width_p-1:0]             release_q, release_d;
  logic [width_p-1:0][HOLD_W-1:0] hold_q, hold_d;
  logic [width_p-1:0]             phase_q, phase_d;
  logic [width_p-1:0]             repeat_q, repeat_d;
  logic [width_p-1:0]             trig_q, trig_d;

  always_comb begin
    // Synchronizer stage: polarity normalised so 1 = pressed.
    sync1_d = (active_low_p != 0) ? ~keys_i : keys_i;
    sync2_d = sync1_q;

    for (int i = 0; i < width_p; i++) begin
      // Debounce stage: count consecutive disagreeing samples.
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      press_d[i]   = level_d[i] & ~level_q[i];
      release_d[i] = ~level_d[i] & level_q[i];

      // Repeat stage: hold_q counts cycles since the press (phase 0) or
      // since the last repeat (phase 1); restarting at each pulse keeps
      // the cadence exact for any delay/period ratio.
      hold_d[i]   = '0;
      phase_d[i]  = 1'b0;
      repeat_d[i] = 1'b0;
      if (level_q[i] & level_d[i]) begin
        phase_d[i] = phase_q[i];
        hold_d[i]  = sat_inc(hold_q[i]);
        if (hold_q[i] == (phase_q[i] ? PERIOD_LAST : DELAY_LAST)) begin
          repeat_d[i] = repeat_mask_p[i];
          hold_d[i]   = '0;
          phase_d[i]  = 1'b1;
        end
      end

      trig_d[i] = press_d[i] | repeat_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      hold_q    <= '0;
      phase_q   <= '0;
      repeat_q  <= '0;
      trig_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      phase_q   <= phase_d;
      repeat_q  <= repeat_d;
      trig_q    <= trig_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;
  assign trig_o    = trig_q;

endmodule
